// File: rtl/dma_priority_resolver_if.sv
// ============================================================================
// Module  : dma_priority_resolver_if
// Brief   : Request/grant bundle between the DMA command/timing logic and
//           the channel priority resolver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_priority_resolver_if;
  logic [3:0] DREQ;
  logic       dreq_sense_low;
  logic       dack_sense_high;
  logic       rotate_en;
  logic       ctrl_disable;
  logic [3:0] mask;
  logic [3:0] sw_req_set;
  logic [3:0] autoinit;
  logic       idle_cycle;
  logic       dack_en;
  logic       cycle_done;
  logic       tc;
  logic [3:0] valid_dreq;
  logic [3:0] DACK;
  logic [1:0] grant_ch;
  logic [3:0] auto_mask_set;
  logic [3:0] sw_req;

  // Resolver side
  modport slave (
    input  DREQ, dreq_sense_low, dack_sense_high, rotate_en, ctrl_disable,
           mask, sw_req_set, autoinit, idle_cycle, dack_en, cycle_done, tc,
    output valid_dreq, DACK, grant_ch, auto_mask_set, sw_req
  );

  // Command/timing side
  modport master (
    output DREQ, dreq_sense_low, dack_sense_high, rotate_en, ctrl_disable,
           mask, sw_req_set, autoinit, idle_cycle, dack_en, cycle_done, tc,
    input  valid_dreq, DACK, grant_ch, auto_mask_set, sw_req
  );
endinterface

`default_nettype wire

// File: rtl/dma_priority_resolver.sv
// ============================================================================
// Module  : dma_priority_resolver
// Brief   : 4-channel DMA request synchronizer, priority arbiter and DACK
//           generator. Optional macro DMA_ROTATE_PRIORITY_EN enables
//           rotating priority via rotate_en.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_resolver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  dma_priority_resolver_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARB     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_valid;
  logic [3:0] r_dack;
  logic [3:0] r_auto_mask;
  logic [3:0] r_sw_req;
  logic [1:0] r_grant_ch;

  logic [3:0] w_pend;
  logic       w_any_pend;
  logic [1:0] w_start;
  logic [1:0] w_win_ch;
  logic [3:0] w_win_onehot;
  logic [3:0] w_grant_onehot;
  logic [3:0] w_sw_clr;
  logic [3:0] w_dack_next;

  // Raw DREQ pins are asynchronous to CLK
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 4'b0000;
    end else begin
      r_sync[0] <= bus.DREQ;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_pend     = ((r_sync[SYNC_STAGES-1] ^ {4{bus.dreq_sense_low}}) & ~bus.mask)
                      | r_sw_req;
  assign w_any_pend = |w_pend;

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] r_last;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_last <= 2'd3;
    else if (r_state == S_RELEASE)
      r_last <= r_grant_ch;
  end

  assign w_start = bus.rotate_en ? (r_last + 2'd1) : 2'd0;
`else
  logic w_unused_rotate;

  assign w_unused_rotate = bus.rotate_en;
  assign w_start         = 2'd0;
`endif

  // Scan from the start channel upward, wrapping modulo 4
  always_comb begin
    logic       w_found;
    logic [1:0] w_idx;
    w_found  = 1'b0;
    w_idx    = 2'd0;
    w_win_ch = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_start + 2'(k);
      if (!w_found && w_pend[w_idx]) begin
        w_found  = 1'b1;
        w_win_ch = w_idx;
      end
    end
  end

  assign w_win_onehot   = 4'b0001 << w_win_ch;
  assign w_grant_onehot = 4'b0001 << r_grant_ch;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_any_pend && bus.idle_cycle && !bus.ctrl_disable)
                   w_next_state = S_ARB;
      S_ARB:     w_next_state = w_any_pend ? S_GRANT : S_IDLE;
      S_GRANT:   if (bus.cycle_done) w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // DACK drops on the same edge that ends the transfer, so it is idle in RELEASE
  always_comb begin
    w_dack_next = {4{~bus.dack_sense_high}};
    if (r_state == S_GRANT && bus.dack_en && !bus.cycle_done)
      w_dack_next = bus.dack_sense_high ? w_grant_onehot : ~w_grant_onehot;
  end

  assign w_sw_clr = (r_state == S_RELEASE) ? w_grant_onehot : 4'b0000;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_grant_ch  <= 2'd0;
      r_valid     <= 4'b0000;
      r_dack      <= 4'b1111;
      r_auto_mask <= 4'b0000;
      r_sw_req    <= 4'b0000;
    end else begin
      r_sw_req    <= (r_sw_req & ~w_sw_clr) | bus.sw_req_set;
      r_dack      <= w_dack_next;
      r_auto_mask <= 4'b0000;
      case (r_state)
        S_ARB: begin
          if (w_any_pend) begin
            r_grant_ch <= w_win_ch;
            r_valid    <= w_win_onehot;
          end
        end
        S_GRANT: begin
          if (bus.cycle_done) begin
            r_valid <= 4'b0000;
            if (bus.tc && !bus.autoinit[r_grant_ch])
              r_auto_mask <= w_grant_onehot;
          end
        end
        S_RELEASE: r_valid <= 4'b0000;
        default:   ;
      endcase
    end
  end

  assign bus.valid_dreq    = r_valid;
  assign bus.DACK          = r_dack;
  assign bus.grant_ch      = r_grant_ch;
  assign bus.auto_mask_set = r_auto_mask;
  assign bus.sw_req        = r_sw_req;

endmodule

`default_nettype wire

// File: tb/tb_dma_priority_resolver.sv
// ============================================================================
// Module  : tb_dma_priority_resolver
// Brief   : Self-checking bench for dma_priority_resolver (vector table plus
//           scoreboard queue, with directed reset/disable/set-vs-clear cases).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_priority_resolver;

  localparam int SYNC = 2;
`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [3:0] sw_set;
    logic       sense_low;
    logic       rot;
    logic       tc;
    logic [3:0] autoinit;
    logic       drop;
    logic [1:0] exp_ch;
    logic [3:0] exp_auto;
    logic [3:0] exp_sw_after;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] auto_m;
    logic [3:0] sw_after;
  } exp_t;

  logic CLK;
  logic RESET_N;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  vec_t vecs[11];

  dma_priority_resolver_if bus();

  dma_priority_resolver #(.SYNC_STAGES(SYNC)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] ch);
    logic [3:0] r;
    r = 4'b0001 << ch;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] dreq, input logic [3:0] mask,
                              input logic [3:0] sw_set, input logic sense_low,
                              input logic rot, input logic tc,
                              input logic [3:0] autoinit, input logic drop,
                              input logic [1:0] exp_ch, input logic [3:0] exp_auto);
    vec_t v;
    v.dreq = dreq; v.mask = mask; v.sw_set = sw_set; v.sense_low = sense_low;
    v.rot = rot; v.tc = tc; v.autoinit = autoinit; v.drop = drop;
    v.exp_ch = exp_ch; v.exp_auto = exp_auto; v.exp_sw_after = 4'b0000;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t       e;
    int         n;
    logic [3:0] dack_act;
    bus.idle_cycle     = 1'b0;
    bus.DREQ           = v.dreq;
    bus.mask           = v.mask;
    bus.dreq_sense_low = v.sense_low;
    bus.rotate_en      = v.rot;
    bus.autoinit       = v.autoinit;
    repeat (SYNC + 2) @(negedge CLK);
    bus.sw_req_set = v.sw_set;
    @(negedge CLK);
    bus.sw_req_set = 4'b0000;
    e.ch = v.exp_ch; e.auto_m = v.exp_auto; e.sw_after = v.exp_sw_after;
    sb.push_back(e);
    bus.idle_cycle = 1'b1;
    n = 0;
    while (bus.valid_dreq === 4'b0000 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    e = sb.pop_front();
    check("grant_latency", n, 2);
    check("valid_dreq", bus.valid_dreq, onehot(e.ch));
    if (bus.valid_dreq === 4'b0000) return;
    check("grant_ch", bus.grant_ch, e.ch);
    check("dack_before_en", bus.DACK, {4{~bus.dack_sense_high}});
    bus.dack_en = 1'b1;
    if (v.drop) bus.DREQ[e.ch] = v.sense_low;
    @(negedge CLK);
    dack_act = bus.dack_sense_high ? onehot(e.ch) : ~onehot(e.ch);
    check("dack_active", bus.DACK, dack_act);
    bus.cycle_done = 1'b1;
    bus.tc         = v.tc;
    bus.idle_cycle = 1'b0;
    @(negedge CLK);
    bus.cycle_done = 1'b0;
    bus.tc         = 1'b0;
    bus.dack_en    = 1'b0;
    check("auto_mask_set", bus.auto_mask_set, e.auto_m);
    check("valid_release", bus.valid_dreq, 4'b0000);
    check("dack_release", bus.DACK, {4{~bus.dack_sense_high}});
    @(negedge CLK);
    check("auto_mask_end", bus.auto_mask_set, 4'b0000);
    check("sw_req_after", bus.sw_req, e.sw_after);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    bus.DREQ = 4'b0000; bus.dreq_sense_low = 1'b0; bus.dack_sense_high = 1'b0;
    bus.rotate_en = 1'b0; bus.ctrl_disable = 1'b0; bus.mask = 4'b0000;
    bus.sw_req_set = 4'b0000; bus.autoinit = 4'b0000; bus.idle_cycle = 1'b0;
    bus.dack_en = 1'b0; bus.cycle_done = 1'b0; bus.tc = 1'b0;

    vecs[0]  = mk(4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000);
    vecs[1]  = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b0000);
    vecs[2]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000);
    vecs[3]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, ROT ? 2'd1 : 2'd0, 4'b0000);
    vecs[4]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, ROT ? 2'd2 : 2'd0, 4'b0000);
    vecs[5]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, ROT ? 2'd3 : 2'd0, 4'b0000);
    vecs[6]  = mk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000);
    vecs[7]  = mk(4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000);
    vecs[8]  = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 4'b0010);
    vecs[9]  = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0000);
    vecs[10] = mk(4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000);

    // Reset state
    RESET_N = 1'b1;
    #2 RESET_N = 1'b0;
    #1;
    check("rst_dack", bus.DACK, 4'b1111);
    check("rst_valid", bus.valid_dreq, 4'b0000);
    check("rst_grant_ch", bus.grant_ch, 2'd0);
    check("rst_sw_req", bus.sw_req, 4'b0000);
    check("rst_auto_mask", bus.auto_mask_set, 4'b0000);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_dack_low_sense", bus.DACK, 4'b1111);

    foreach (vecs[i]) run_vec(vecs[i]);

    // A software set in RELEASE wins over the clear of the same bit
    bus.DREQ = 4'b0000; bus.mask = 4'b1111; bus.dreq_sense_low = 1'b0; bus.rotate_en = 1'b0;
    repeat (SYNC + 2) @(negedge CLK);
    bus.sw_req_set = 4'b0001;
    @(negedge CLK);
    bus.sw_req_set = 4'b0000;
    bus.idle_cycle = 1'b1;
    n = 0;
    while (bus.valid_dreq === 4'b0000 && n < 20) begin @(negedge CLK); n++; end
    check("sw_grant_ch0", bus.valid_dreq, 4'b0001);
    bus.cycle_done = 1'b1; bus.idle_cycle = 1'b0;
    @(negedge CLK);
    bus.cycle_done = 1'b0;
    bus.sw_req_set = 4'b0001;
    @(negedge CLK);
    bus.sw_req_set = 4'b0000;
    check("sw_set_wins", bus.sw_req, 4'b0001);

    // ctrl_disable blocks new arbitration but not an existing grant
    bus.ctrl_disable = 1'b1; bus.idle_cycle = 1'b1;
    repeat (6) @(negedge CLK);
    check("ctrl_disable_blocks", bus.valid_dreq, 4'b0000);
    bus.ctrl_disable = 1'b0;
    n = 0;
    while (bus.valid_dreq === 4'b0000 && n < 20) begin @(negedge CLK); n++; end
    check("grant_after_enable", bus.valid_dreq, 4'b0001);
    bus.ctrl_disable = 1'b1; bus.idle_cycle = 1'b0;
    repeat (3) @(negedge CLK);
    check("hold_under_disable", bus.valid_dreq, 4'b0001);
    bus.dack_sense_high = 1'b1; bus.dack_en = 1'b1;
    @(negedge CLK);
    check("dack_high_active", bus.DACK, 4'b0001);

    // Asynchronous reset in the middle of a grant
    #2 RESET_N = 1'b0;
    #1;
    check("midgrant_rst_dack", bus.DACK, 4'b1111);
    check("midgrant_rst_valid", bus.valid_dreq, 4'b0000);
    check("midgrant_rst_sw", bus.sw_req, 4'b0000);
    check("midgrant_rst_auto", bus.auto_mask_set, 4'b0000);
    bus.dack_en = 1'b0; bus.ctrl_disable = 1'b0; bus.mask = 4'b0000;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_dack_high_sense", bus.DACK, 4'b0000);
    check("post_rst_auto", bus.auto_mask_set, 4'b0000);
    check("post_rst_valid", bus.valid_dreq, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
